// File: rtl/shared_adder_pkg.sv
// Shared types and constants for the nibble-serial shared adder scheduler.
package shared_adder_pkg;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} sched_state_t;

    localparam int SLICE_W = 4;

endpackage

// File: rtl/cla_slice_4.sv
// Combinational 4-bit carry-lookahead adder slice: {o_co, o_s} = i_a + i_b + i_ci.
module cla_slice_4 (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_ci,
    output logic [3:0] o_s,
    output logic       o_co
);

    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_c;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    // Carries flattened from generate/propagate terms rather than rippled.
    assign w_c[0] = i_ci;
    assign w_c[1] = w_g[0] | (w_p[0] & i_ci);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_ci);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_ci);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_ci);

    assign o_s  = w_p ^ w_c[3:0];
    assign o_co = w_c[4];

endmodule

// File: rtl/shared_adder_sched.sv
// Round-robin scheduler sharing one 4-bit CLA slice between two requesters;
// each request is summed one nibble per cycle, LSB nibble first.
module shared_adder_sched
    import shared_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_ci,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_ci,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_co
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_bad_width
        $fatal(1, "shared_adder_sched: WIDTH must be a positive multiple of 4");
    end

    sched_state_t     r_state;
    sched_state_t     w_state_next;
    logic             r_rr_ptr;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_id;
    logic [IDX_W-1:0] r_slice_idx;

    logic             w_accept;
    logic             w_grant_id;
    logic             w_last;
    logic [WIDTH-1:0] w_a_in;
    logic [WIDTH-1:0] w_b_in;
    logic             w_ci_in;
    logic [SLICE_W-1:0]       w_s;
    logic                     w_co;
    logic [WIDTH+SLICE_W-1:0] w_sum_shift;

    // Contention goes to the rr pointer; a lone valid wins outright.
    assign w_grant_id = (req0_valid && req1_valid) ? r_rr_ptr : req1_valid;
    assign w_a_in     = w_grant_id ? req1_a  : req0_a;
    assign w_b_in     = w_grant_id ? req1_b  : req0_b;
    assign w_ci_in    = w_grant_id ? req1_ci : req0_ci;
    assign w_last     = (r_slice_idx == IDX_W'(NSLICE - 1));

    // Operands shift right so the active nibble is always at the bottom;
    // sum nibbles enter at the top and settle into place after NSLICE passes.
    cla_slice_4 u_slice (
        .i_a  (r_a[SLICE_W-1:0]),
        .i_b  (r_b[SLICE_W-1:0]),
        .i_ci (r_carry),
        .o_s  (w_s),
        .o_co (w_co)
    );

    assign w_sum_shift = {w_s, r_sum};

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (req0_valid || req1_valid) begin
                    w_accept     = 1'b1;
                    req0_ready   = ~w_grant_id;
                    req1_ready   = w_grant_id;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) w_state_next = S_DONE;
            end
            S_DONE: begin
                if (rsp_ready) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_carry     <= 1'b0;
            r_id        <= 1'b0;
            r_slice_idx <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a         <= w_a_in;
                        r_b         <= w_b_in;
                        r_carry     <= w_ci_in;
                        r_id        <= w_grant_id;
                        r_slice_idx <= '0;
                        r_rr_ptr    <= ~w_grant_id;
                    end
                end
                S_RUN: begin
                    r_a         <= r_a >> SLICE_W;
                    r_b         <= r_b >> SLICE_W;
                    r_sum       <= w_sum_shift[WIDTH+SLICE_W-1:SLICE_W];
                    r_carry     <= w_co;
                    r_slice_idx <= r_slice_idx + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid = (r_state == S_DONE);
    assign rsp_id    = r_id;
    assign rsp_sum   = r_sum;
    assign rsp_co    = r_carry;

endmodule

// File: tb/tb_shared_adder_sched.sv
// Directed bench for shared_adder_sched: WIDTH=16 instance plus a WIDTH=4 instance.
module tb_shared_adder_sched;

    logic        clk;
    logic        rst;
    logic        req0_valid, req0_ready, req0_ci;
    logic        req1_valid, req1_ready, req1_ci;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_co;
    logic [15:0] rsp_sum;

    logic        d4_req0_valid, d4_req0_ready, d4_req0_ci;
    logic        d4_req1_valid, d4_req1_ready, d4_req1_ci;
    logic [3:0]  d4_req0_a, d4_req0_b, d4_req1_a, d4_req1_b;
    logic        d4_rsp_valid, d4_rsp_ready, d4_rsp_id, d4_rsp_co;
    logic [3:0]  d4_rsp_sum;

    int checks = 0;
    int errors = 0;

    shared_adder_sched #(.WIDTH(16)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ci    (req0_ci),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ci    (req1_ci),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_sum    (rsp_sum),
        .rsp_co     (rsp_co)
    );

    shared_adder_sched #(.WIDTH(4)) u_dut4 (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (d4_req0_valid),
        .req0_ready (d4_req0_ready),
        .req0_a     (d4_req0_a),
        .req0_b     (d4_req0_b),
        .req0_ci    (d4_req0_ci),
        .req1_valid (d4_req1_valid),
        .req1_ready (d4_req1_ready),
        .req1_a     (d4_req1_a),
        .req1_b     (d4_req1_b),
        .req1_ci    (d4_req1_ci),
        .rsp_valid  (d4_rsp_valid),
        .rsp_ready  (d4_rsp_ready),
        .rsp_id     (d4_rsp_id),
        .rsp_sum    (d4_rsp_sum),
        .rsp_co     (d4_rsp_co)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin : stim
        int lat;
        int n_acc;
        int n_rsp;
        int cyc;
        int acc_cyc[8];
        int acc_id[8];

        rst = 1'b1;
        req0_valid = 0; req0_a = '0; req0_b = '0; req0_ci = 0;
        req1_valid = 0; req1_a = '0; req1_b = '0; req1_ci = 0;
        rsp_ready = 0;
        d4_req0_valid = 0; d4_req0_a = '0; d4_req0_b = '0; d4_req0_ci = 0;
        d4_req1_valid = 0; d4_req1_a = '0; d4_req1_b = '0; d4_req1_ci = 0;
        d4_rsp_ready = 0;
        step();
        step();
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_sum", 32'(rsp_sum), 0);
        chk("rst_rsp_co", 32'(rsp_co), 0);
        chk("rst_rsp_id", 32'(rsp_id), 0);
        rst = 1'b0;
        step();

        // 1: carry ripples through every nibble
        req0_valid = 1; req0_a = 16'hFFFF; req0_b = 16'h0001; req0_ci = 0; rsp_ready = 1;
        #1;
        chk("t1_req0_ready", 32'(req0_ready), 1);
        chk("t1_req1_ready", 32'(req1_ready), 0);
        step();
        req0_valid = 0; req0_a = 16'h1357; req0_b = 16'h2468; req0_ci = 1;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            step();
            lat++;
        end
        chk("t1_latency", 32'(lat), 4);
        chk("t1_sum", 32'(rsp_sum), 32'h0000);
        chk("t1_co", 32'(rsp_co), 1);
        chk("t1_id", 32'(rsp_id), 0);
        step();
        chk("t1_rsp_drop", 32'(rsp_valid), 0);

        // 2: requester 1, req0 locked out during RUN/DONE
        req1_valid = 1; req1_a = 16'h1234; req1_b = 16'h4321; req1_ci = 1; rsp_ready = 0;
        #1;
        chk("t2_req1_ready", 32'(req1_ready), 1);
        step();
        req1_valid = 0;
        req0_valid = 1; req0_a = 16'h0F0F; req0_b = 16'h0101; req0_ci = 0;
        #1;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            chk("t2_req0_ready_run", 32'(req0_ready), 0);
            step();
            lat++;
        end
        chk("t2_latency", 32'(lat), 4);
        chk("t2_sum", 32'(rsp_sum), 32'h5556);
        chk("t2_co", 32'(rsp_co), 0);
        chk("t2_id", 32'(rsp_id), 1);
        chk("t2_req0_ready_done", 32'(req0_ready), 0);
        req0_valid = 0; rsp_ready = 1;
        step();
        chk("t2_rsp_drop", 32'(rsp_valid), 0);

        // 3: both valid continuously, rr pointer at 0
        req0_valid = 1; req0_a = 16'h0001; req0_b = 16'h0002; req0_ci = 0;
        req1_valid = 1; req1_a = 16'h8000; req1_b = 16'h8000; req1_ci = 1;
        rsp_ready = 1;
        #1;
        n_acc = 0;
        n_rsp = 0;
        for (cyc = 0; cyc < 24; cyc++) begin
            if ((req0_ready || req1_ready) && n_acc < 8) begin
                acc_cyc[n_acc] = cyc;
                acc_id[n_acc] = req1_ready ? 1 : 0;
                n_acc++;
            end
            if (rsp_valid) begin
                chk("t3_rsp_id", 32'(rsp_id), 32'(n_rsp % 2));
                chk("t3_rsp_sum", 32'(rsp_sum), (n_rsp % 2 == 0) ? 32'h0003 : 32'h0001);
                chk("t3_rsp_co", 32'(rsp_co), (n_rsp % 2 == 0) ? 32'd0 : 32'd1);
                n_rsp++;
            end
            if (cyc == 23) begin
                req0_valid = 0;
                req1_valid = 0;
            end
            step();
        end
        chk("t3_n_acc", 32'(n_acc), 4);
        chk("t3_n_rsp", 32'(n_rsp), 4);
        for (int i = 0; i < 4 && i < n_acc; i++) begin
            chk("t3_grant_id", 32'(acc_id[i]), 32'(i % 2));
            chk("t3_accept_cycle", 32'(acc_cyc[i]), 32'(6 * i));
        end
        chk("t3_idle", 32'(rsp_valid), 0);

        // 4: stalled response stays stable and blocks new accepts
        rsp_ready = 0;
        req0_valid = 1; req0_a = 16'hC000; req0_b = 16'h4001; req0_ci = 1;
        #1;
        chk("t4_req0_ready", 32'(req0_ready), 1);
        step();
        req0_valid = 0;
        req1_valid = 1; req1_a = 16'h0001; req1_b = 16'h0001; req1_ci = 0;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            step();
            lat++;
        end
        chk("t4_latency", 32'(lat), 4);
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_valid", 32'(rsp_valid), 1);
            chk("t4_hold_sum", 32'(rsp_sum), 32'h0002);
            chk("t4_hold_co", 32'(rsp_co), 1);
            chk("t4_hold_id", 32'(rsp_id), 0);
            chk("t4_hold_req1_ready", 32'(req1_ready), 0);
            step();
        end
        rsp_ready = 1;
        step();
        chk("t4_taken", 32'(rsp_valid), 0);
        chk("t4_req1_ready_after", 32'(req1_ready), 1);
        req1_valid = 0;
        step();

        // 5: reset mid-RUN discards the in-flight sum and restores req0 preference
        rsp_ready = 1;
        req0_valid = 1; req0_a = 16'h1111; req0_b = 16'h2222; req0_ci = 1;
        #1;
        chk("t5_req0_ready", 32'(req0_ready), 1);
        step();
        req0_valid = 0;
        step();
        rst = 1;
        step();
        rst = 0;
        chk("t5_rsp_valid", 32'(rsp_valid), 0);
        chk("t5_rsp_sum", 32'(rsp_sum), 0);
        chk("t5_rsp_co", 32'(rsp_co), 0);
        chk("t5_rsp_id", 32'(rsp_id), 0);
        req0_valid = 1; req1_valid = 1;
        #1;
        chk("t5_pref_req0", 32'(req0_ready), 1);
        chk("t5_pref_req1", 32'(req1_ready), 0);
        req0_valid = 0; req1_valid = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t5_no_pulse", 32'(rsp_valid), 0);
        end

        // 6: WIDTH=4 single-pass
        d4_req0_valid = 1; d4_req0_a = 4'hF; d4_req0_b = 4'hF; d4_req0_ci = 1;
        #1;
        chk("t6_ready", 32'(d4_req0_ready), 1);
        step();
        d4_req0_valid = 0;
        lat = 0;
        while (!d4_rsp_valid && lat < 20) begin
            step();
            lat++;
        end
        chk("t6_latency", 32'(lat), 1);
        chk("t6_sum", 32'(d4_rsp_sum), 32'hF);
        chk("t6_co", 32'(d4_rsp_co), 1);
        chk("t6_id", 32'(d4_rsp_id), 0);
        d4_rsp_ready = 1;
        step();
        chk("t6_taken", 32'(d4_rsp_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
